// File: rtl/fadd_accum.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fadd_accum : FP32 streaming accumulator around a combinational fadd;    |
// | define FADD_ACCUM_FLAGS_EN for sticky NaN/inf flags.  Rev 1.0           |
// +-------------------------------------------------------------------------+

module fadd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap, sx, sy, sub, rup;
  logic [7:0]  ex, ey, ex_eff, ey_eff, d;
  logic [22:0] mx, my;
  logic [26:0] sig_x, sig_y, y_al, y_mask, norm;
  logic [27:0] sum_raw;
  logic [9:0]  exp_n;
  logic [4:0]  lz;
  logic [30:0] packed_r;
  logic        unused_bits;

  assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

  // x is always the operand of larger magnitude, so x - y never goes negative
  assign swap         = b[30:0] > a[30:0];
  assign {sx, ex, mx} = swap ? b : a;
  assign {sy, ey, my} = swap ? a : b;
  assign sub          = sx ^ sy;
  assign ex_eff       = (ex == 8'd0) ? 8'd1 : ex;
  assign ey_eff       = (ey == 8'd0) ? 8'd1 : ey;
  assign d            = ex_eff - ey_eff;
  assign sig_x        = {ex != 8'd0, mx, 3'b000};
  assign sig_y        = {ey != 8'd0, my, 3'b000};

  always_comb begin
    y_mask = '0;
    y_al   = '0;
    if (d < 8'd27) begin
      y_mask   = (27'd1 << d[4:0]) - 27'd1;
      y_al     = sig_y >> d[4:0];
      y_al[0]  = y_al[0] | (|(sig_y & y_mask));
    end else begin
      y_al = {26'd0, |sig_y};
    end
  end

  assign sum_raw = sub ? ({1'b0, sig_x} - {1'b0, y_al})
                       : ({1'b0, sig_x} + {1'b0, y_al});

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum_raw[i]) lz = 5'(26 - i);
    end
  end

  // Left shift is capped so the exponent bottoms out at the subnormal range
  always_comb begin
    norm  = '0;
    exp_n = '0;
    if (sum_raw[27]) begin
      norm  = {sum_raw[27:2], sum_raw[1] | sum_raw[0]};
      exp_n = {2'b00, ex_eff} + 10'd1;
    end else if ({3'b000, lz} < ex_eff) begin
      norm  = sum_raw[26:0] << lz;
      exp_n = {2'b00, ex_eff} - {5'd0, lz};
    end else begin
      norm  = sum_raw[26:0] << (ex_eff - 8'd1);
      exp_n = '0;
    end
  end

  // Mantissa carry ripples into the exponent: covers subnormal->normal and overflow->inf
  assign rup         = norm[2] & (norm[3] | norm[1] | norm[0]);
  assign packed_r    = {exp_n[7:0], norm[25:3]} + {30'd0, rup};
  assign unused_bits = norm[26];

  always_comb begin
    if (a_nan)
      y = {a[31], 8'hFF, 1'b1, a[21:0]};
    else if (b_nan)
      y = {b[31], 8'hFF, 1'b1, b[21:0]};
    else if (a_inf && b_inf && (a[31] != b[31]))
      y = 32'hFFC0_0000;
    else if (a_inf)
      y = a;
    else if (b_inf)
      y = b;
    else if (sum_raw == 28'd0)
      y = {a[31] & b[31], 31'd0};
    else if (exp_n >= 10'd255)
      y = {sx, 8'hFF, 23'd0};
    else
      y = {sx, packed_r};
  end
endmodule

module fadd_accum #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef FADD_ACCUM_FLAGS_EN
  ,
  output logic             flag_nan,
  output logic             flag_inf
`endif
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      acc, fadd_out;
  logic [CNT_W-1:0] remaining;
  logic             accept, acc_nan, start_ok;

  fadd u_fadd (
    .a (acc),
    .b (in_data),
    .y (fadd_out)
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = acc;
  assign accept    = in_valid && in_ready;
  assign start_ok  = (state == IDLE) && start;
  assign acc_nan   = (acc[30:23] == 8'hFF) && (acc[22:0] != 23'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (accept && (remaining == CNT_W'(1))) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A NaN in the accumulator is frozen so the first payload is what gets reported
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= 32'h0000_0000;
      remaining <= '0;
    end else if (start_ok) begin
      acc       <= 32'h0000_0000;
      remaining <= len;
    end else if (accept) begin
      remaining <= remaining - CNT_W'(1);
      if (!acc_nan) acc <= fadd_out;
    end
  end

`ifdef FADD_ACCUM_FLAGS_EN
  logic out_nan, out_inf;
  assign out_nan = (fadd_out[30:23] == 8'hFF) && (fadd_out[22:0] != 23'd0);
  assign out_inf = (fadd_out[30:23] == 8'hFF) && (fadd_out[22:0] == 23'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_nan <= 1'b0;
      flag_inf <= 1'b0;
    end else if (start_ok) begin
      flag_nan <= 1'b0;
      flag_inf <= 1'b0;
    end else if (accept) begin
      flag_nan <= flag_nan | out_nan;
      flag_inf <= flag_inf | out_inf;
    end
  end
`endif
endmodule

`default_nettype wire

// File: tb/tb_fadd_accum.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fadd_accum : directed self-checking bench for fadd_accum. Rev 1.0    |
// +-------------------------------------------------------------------------+

module tb_fadd_accum;
  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, out_ready;
  logic [7:0]  len;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] sum;
`ifdef FADD_ACCUM_FLAGS_EN
  logic        flag_nan, flag_inf;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fadd_accum #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef FADD_ACCUM_FLAGS_EN
    ,
    .flag_nan  (flag_nan),
    .flag_inf  (flag_inf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic begin_pass(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick;
    start = 1'b0;
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  // Feeds elements back-to-back, one accept per cycle
  task automatic feed2(input logic [31:0] d0, input logic [31:0] d1);
    in_valid = 1'b1;
    in_data  = d0;
    tick;
    in_data  = d1;
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_data = 32'd0; out_ready = 1'b0;
    tick; tick;
    check("rst_sum", sum, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick;

    // 1.0 x3 back-to-back
    begin_pass(8'd3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 32'h3F80_0000;
    tick; tick;
    check("t1_not_done", 32'(out_valid), 32'd0);
    tick;
    in_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_in_ready_drop", 32'(in_ready), 32'd0);
    check("t1_sum", sum, 32'h4040_0000);
    release_out;
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_sum_retained", sum, 32'h4040_0000);

    // zero-length pass
    begin_pass(8'd0);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_sum", sum, 32'd0);
    check("t2_in_ready", 32'(in_ready), 32'd0);
`ifdef FADD_ACCUM_FLAGS_EN
    check("t2_flags", {30'd0, flag_nan, flag_inf}, 32'd0);
`endif
    release_out;
    check("t2_busy", 32'(busy), 32'd0);

    // gap in in_valid; the subtraction ends on a round-to-even tie
    begin_pass(8'd2);
    in_valid = 1'b1; in_data = 32'h4049_999A;
    tick;
    in_valid = 1'b0; in_data = 32'h3F80_0000;
    tick;
    check("t3_gap_sum", sum, 32'h4049_999A);
    check("t3_gap_ready", 32'(in_ready), 32'd1);
    check("t3_gap_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 32'hC166_3D71;
    tick;
    in_valid = 1'b0;
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_sum", sum, 32'hC133_D70A);
    release_out;

    // inf + -inf -> default NaN, then frozen
    begin_pass(8'd3);
    in_valid = 1'b1; in_data = 32'h7F80_0000;
    tick;
    check("t4_inf", sum, 32'h7F80_0000);
    feed2(32'hFF80_0000, 32'h3F80_0000);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    check("t4_sum", sum, 32'hFFC0_0000);
`ifdef FADD_ACCUM_FLAGS_EN
    check("t4_flag_nan", 32'(flag_nan), 32'd1);
    check("t4_flag_inf", 32'(flag_inf), 32'd1);
`endif

    // DONE held with out_ready low; start is ignored
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd7;
      tick;
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_sum", sum, 32'hFFC0_0000);
    end
    start = 1'b0;
    release_out;
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_valid", 32'(out_valid), 32'd0);

    // asynchronous reset mid-pass
    begin_pass(8'd4);
    feed2(32'h3F80_0000, 32'h3F80_0000);
    check("t6_partial", sum, 32'h4000_0000);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_sum", sum, 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    begin_pass(8'd1);
    in_valid = 1'b1; in_data = 32'h4600_0000;
    tick;
    in_valid = 1'b0;
    check("t6_out_valid", 32'(out_valid), 32'd1);
    check("t6_sum", sum, 32'h4600_0000);
    release_out;

    // signalling NaN payload is quieted and kept
    begin_pass(8'd2);
    feed2(32'h7FA0_0001, 32'h3F80_0000);
    check("t7_nan_payload", sum, 32'h7FE0_0001);
`ifdef FADD_ACCUM_FLAGS_EN
    check("t7_flag_nan", 32'(flag_nan), 32'd1);
    check("t7_flag_inf", 32'(flag_inf), 32'd0);
`endif
    release_out;

    // subnormal addition and exact cancellation
    begin_pass(8'd2);
    feed2(32'h0000_0001, 32'h0000_0001);
    check("t8_subnormal", sum, 32'h0000_0002);
    release_out;
    begin_pass(8'd2);
    feed2(32'h3F80_0000, 32'hBF80_0000);
    check("t8_cancel", sum, 32'h0000_0000);
    release_out;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire
